// File: rtl/dmadd_cmd_loader.sv
// Byte-stream command loader for the DMADD core: unpacks header/payload frames
// into one-cycle load strobes followed by a fixed-length run burst.
module dmadd_cmd_loader #(
   parameter int RUN_CYCLES = 8,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   input  logic [7:0]       s_data,
   output logic             s_ready,
   input  logic             abort,
   output logic             dm_load,
   output logic [3:0]       dm_index,
   output logic [3:0]       dm_data,
   output logic [1:0]       dm_insn,
   output logic             dm_run,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] frame_cnt
);

   // Handshake: a byte moves on any rising edge where s_valid && s_ready;
   // s_ready depends only on state and abort, never on s_valid.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_SETTLE = 2'd2;
   localparam logic [1:0] ST_RUN    = 2'd3;

   logic [1:0] state;
   logic [3:0] remain;
   logic [7:0] run_cnt;
   logic       xfer;

   assign s_ready = ((state == ST_IDLE) || (state == ST_LOAD)) && !abort;
   assign xfer    = s_valid && s_ready;
   assign busy    = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         remain    <= 4'd0;
         run_cnt   <= 8'd0;
         dm_load   <= 1'b0;
         dm_index  <= 4'd0;
         dm_data   <= 4'd0;
         dm_insn   <= 2'd0;
         dm_run    <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         frame_cnt <= '0;
      end else begin
         dm_load <= 1'b0;
         done    <= 1'b0;
         if (abort) begin
            state   <= ST_IDLE;
            remain  <= 4'd0;
            run_cnt <= 8'd0;
            dm_run  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (xfer) begin
                     if (s_data[5:4] != 2'b00) begin
                        err <= 1'b1;
                     end else begin
                        dm_insn <= s_data[7:6];
                        remain  <= s_data[3:0];
                        state   <= (s_data[3:0] == 4'd0) ? ST_SETTLE : ST_LOAD;
                     end
                  end
               end
               ST_LOAD: begin
                  if (xfer) begin
                     dm_load  <= 1'b1;
                     dm_index <= s_data[7:4];
                     dm_data  <= s_data[3:0];
                     remain   <= remain - 4'd1;
                     if (remain == 4'd1) state <= ST_SETTLE;
                  end
               end
               // Settle lets the final load strobe retire before run rises.
               ST_SETTLE: begin
                  state   <= ST_RUN;
                  dm_run  <= 1'b1;
                  run_cnt <= 8'(RUN_CYCLES);
               end
               default: begin
                  if (run_cnt <= 8'd1) begin
                     dm_run    <= 1'b0;
                     done      <= 1'b1;
                     frame_cnt <= frame_cnt + CNT_W'(1);
                     state     <= ST_IDLE;
                  end else begin
                     run_cnt <= run_cnt - 8'd1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dmadd_cmd_loader.sv
// Self-checking bench for dmadd_cmd_loader: scenario tasks plus a load-strobe
// scoreboard fed by the byte driver.
module tb_dmadd_cmd_loader;

   localparam int RC = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = 8'd0;
   logic       s_ready;
   logic       abort = 1'b0;
   logic       dm_load;
   logic [3:0] dm_index;
   logic [3:0] dm_data;
   logic [1:0] dm_insn;
   logic       dm_run;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] frame_cnt;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_frames = 8'd0;

   dmadd_cmd_loader #(.RUN_CYCLES(RC), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .abort(abort), .dm_load(dm_load), .dm_index(dm_index), .dm_data(dm_data),
      .dm_insn(dm_insn), .dm_run(dm_run), .busy(busy), .done(done), .err(err),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // Scoreboard: every dm_load strobe must match the oldest accepted payload.
   always @(negedge clk) begin
      if (!rst) begin
         if (dm_load) begin
            logic [7:0] exp;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL load_unexpected got idx=%0d data=%0d want no load", dm_index, dm_data);
            end else begin
               exp = exp_q.pop_front();
               if ({dm_index, dm_data} !== exp) begin
                  errors++;
                  $display("FAIL load_value got %02h want %02h", {dm_index, dm_data}, exp);
               end
            end
         end
         if (dm_load && dm_run) begin
            errors++;
            $display("FAIL load_run_overlap got load=1 run=1 want not both");
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit payload);
      int n;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      n = 0;
      while (!s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_timeout got s_ready=%0b want 1 byte=%02h", s_ready, b);
         s_valid = 1'b0;
      end else begin
         @(posedge clk);
         if (payload) exp_q.push_back(b);
         #1 s_valid = 1'b0;
      end
   endtask

   // Entered at the negedge of the first cycle dm_run should be high.
   task automatic run_check(input logic [1:0] insn);
      for (int i = 0; i < RC; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if (dm_run !== 1'b1 || s_ready !== 1'b0 || dm_insn !== insn || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL run_cycle%0d got run=%0b ready=%0b insn=%0d busy=%0b done=%0b want 1 0 %0d 1 0",
                     i, dm_run, s_ready, dm_insn, busy, done, insn);
         end
      end
      exp_frames++;
      @(negedge clk);
      checks++;
      if (dm_run !== 1'b0 || done !== 1'b1 || frame_cnt !== exp_frames || busy !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL run_end got run=%0b done=%0b cnt=%0d busy=%0b ready=%0b want 0 1 %0d 0 1",
                  dm_run, done, frame_cnt, busy, s_ready, exp_frames);
      end
   endtask

   // Entered right after the last byte of a frame was accepted.
   task automatic expect_run(input logic [1:0] insn);
      @(negedge clk);
      checks++;
      if (dm_run !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL settle got run=%0b busy=%0b want 0 1", dm_run, busy);
      end
      @(negedge clk);
      run_check(insn);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (dm_load !== 1'b0 || dm_index !== 4'd0 || dm_data !== 4'd0 || dm_insn !== 2'd0 ||
          dm_run !== 1'b0 || done !== 1'b0 || err !== 1'b0 || frame_cnt !== 8'd0 ||
          s_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset got load=%0b idx=%0d data=%0d insn=%0d run=%0b done=%0b err=%0b cnt=%0d ready=%0b busy=%0b want all 0, ready=1",
                  dm_load, dm_index, dm_data, dm_insn, dm_run, done, err, frame_cnt, s_ready, busy);
      end
      rst = 1'b0;
      exp_frames = 8'd0;
      exp_q.delete();
   endtask

   task automatic test_basic_frame();
      send_byte(8'h82, 1'b0);
      send_byte(8'h35, 1'b1);
      send_byte(8'hA7, 1'b1);
      @(negedge clk);
      checks++;
      if (dm_load !== 1'b1 || dm_run !== 1'b0 || dm_insn !== 2'd2) begin
         errors++;
         $display("FAIL basic_last_load got load=%0b run=%0b insn=%0d want 1 0 2", dm_load, dm_run, dm_insn);
      end
      @(negedge clk);
      run_check(2'd2);
   endtask

   task automatic test_gapped_payload();
      logic [7:0] pl[3];
      pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      send_byte(8'h43, 1'b0);
      for (int p = 0; p < 3; p++) begin
         send_byte(pl[p], 1'b1);
         if (p < 2) begin
            @(negedge clk);
            checks++;
            if (dm_load !== 1'b1) begin
               errors++;
               $display("FAIL gap_load%0d got %0b want 1", p, dm_load);
            end
            for (int g = 0; g < 2; g++) begin
               @(negedge clk);
               checks++;
               if (dm_load !== 1'b0 || busy !== 1'b1) begin
                  errors++;
                  $display("FAIL gap_idle%0d got load=%0b busy=%0b want 0 1", p, dm_load, busy);
               end
            end
         end
      end
      expect_run(2'd1);
   endtask

   task automatic test_back_to_back();
      send_byte(8'hC0, 1'b0);
      s_valid = 1'b1;
      s_data  = 8'h01;
      expect_run(2'd3);
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_hdr_accept got busy=%0b done=%0b want 1 0", busy, done);
      end
      send_byte(8'hF0, 1'b1);
      expect_run(2'd0);
   endtask

   task automatic test_malformed();
      send_byte(8'h12, 1'b0);
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || dm_insn !== 2'd0) begin
         errors++;
         $display("FAIL malformed got err=%0b busy=%0b insn=%0d want 1 0 0", err, busy, dm_insn);
      end
      send_byte(8'h41, 1'b0);
      send_byte(8'h5A, 1'b1);
      expect_run(2'd1);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky got %0b want 1", err);
      end
   endtask

   task automatic test_abort_load();
      send_byte(8'h43, 1'b0);
      send_byte(8'h11, 1'b1);
      @(negedge clk);
      abort   = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'h22;
      #1;
      checks++;
      if (s_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_ready got %0b want 0", s_ready);
      end
      @(posedge clk);
      #1 abort = 1'b0;
      s_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (dm_load !== 1'b0 || dm_run !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || frame_cnt !== exp_frames) begin
            errors++;
            $display("FAIL abort_load%0d got load=%0b run=%0b busy=%0b done=%0b cnt=%0d want 0 0 0 0 %0d",
                     i, dm_load, dm_run, busy, done, frame_cnt, exp_frames);
         end
      end
      send_byte(8'h01, 1'b0);
      send_byte(8'h9C, 1'b1);
      expect_run(2'd0);
   endtask

   task automatic test_abort_run();
      send_byte(8'h80, 1'b0);
      @(negedge clk);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         checks++;
         if (dm_run !== 1'b1) begin
            errors++;
            $display("FAIL abort_run_cycle%0d got run=%0b want 1", i, dm_run);
         end
      end
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (dm_run !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || frame_cnt !== exp_frames) begin
            errors++;
            $display("FAIL abort_run_after%0d got run=%0b done=%0b busy=%0b cnt=%0d want 0 0 0 %0d",
                     i, dm_run, done, busy, frame_cnt, exp_frames);
         end
      end
   endtask

   task automatic test_wrap();
      logic [1:0] insn;
      int         n;
      test_reset();
      for (int f = 0; f < 256; f++) begin
         insn = 2'($urandom_range(0, 3));
         n    = $urandom_range(0, 3);
         send_byte({insn, 2'b00, 4'(n)}, 1'b0);
         for (int p = 0; p < n; p++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send_byte(8'($urandom_range(0, 255)), 1'b1);
         end
         expect_run(insn);
      end
      checks++;
      if (frame_cnt !== 8'd0) begin
         errors++;
         $display("FAIL wrap got cnt=%0d want 0", frame_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_gapped_payload();
      test_back_to_back();
      test_malformed();
      test_abort_load();
      test_abort_run();
      test_wrap();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL loads_missing got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
